// File: rtl/ev20_pkg.sv
// Shared definitions for the branch predictor: branch type codes, 2-bit counter
// states, default field widths and the saturating-counter update rule.
package ev20_pkg;

   localparam int BP_PC_W  = 11;
   localparam int BP_IDX_W = 6;
   localparam int BP_Q_DEPTH = 4;

   typedef enum logic [1:0] {
      BR_NONE = 2'b00,
      BR_JZE  = 2'b01,
      BR_JNE  = 2'b10,
      BR_JCY  = 2'b11
   } br_type_e;

   localparam logic [1:0] CNT_SNT = 2'b00;
   localparam logic [1:0] CNT_WNT = 2'b01;
   localparam logic [1:0] CNT_WT  = 2'b10;
   localparam logic [1:0] CNT_ST  = 2'b11;

   // Queue entry at default widths; the top re-declares it from its own parameters.
   typedef struct packed {
      logic [BP_IDX_W-1:0] idx;
      logic [1:0]          br_type;
      logic                pred;
      logic [BP_PC_W-1:0]  target;
      logic [BP_PC_W-1:0]  pc_plus1;
   } bp_entry_t;

   function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
      if (taken)
         return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
      else
         return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
   endfunction

endpackage

// File: rtl/branch_predictor_counter_table.sv
// Table of 2-bit saturating counters: one asynchronous read port for prediction
// and one synchronous training port. The read always sees the pre-update value.
module bp_counter_table
   import ev20_pkg::*;
#(
   parameter int         IDX_W    = BP_IDX_W,
   parameter logic [1:0] CNT_INIT = CNT_WNT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [1:0]       rd_cnt,
   input  logic             upd_en,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_taken
);

   localparam int N_ENT = 2**IDX_W;

   logic [1:0] cnt [N_ENT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_ENT; i++) cnt[i] <= CNT_INIT;
      end else if (upd_en) begin
         cnt[upd_idx] <= sat_update(cnt[upd_idx], upd_taken);
      end
   end

   assign rd_cnt = cnt[rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Conditional-branch predictor: predicts from the counter table, keeps outstanding
// predictions in order, trains on resolution and redirects fetch on a mispredict.
module branch_predictor
   import ev20_pkg::*;
#(
   parameter int         PC_W     = BP_PC_W,
   parameter int         IDX_W    = BP_IDX_W,
   parameter int         Q_DEPTH  = BP_Q_DEPTH,
   parameter logic [1:0] CNT_INIT = CNT_WNT,
   localparam int        PTR_W    = $clog2(Q_DEPTH),
   localparam int        OCC_W    = $clog2(Q_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             issue_valid,
   input  logic [1:0]       issue_type,
   input  logic [PC_W-1:0]  issue_pc,
   input  logic [PC_W-1:0]  issue_target,
   output logic             issue_ready,
   output logic             pred_taken,
   output logic             last_pred,
   output logic [1:0]       pred_type,
   input  logic             resolve_valid,
   input  logic             resolve_taken,
   input  logic             resolve_mispred,
   output logic             redirect,
   output logic [PC_W-1:0]  redirect_pc,
   output logic [OCC_W-1:0] occupancy
);

   typedef struct packed {
      logic [IDX_W-1:0] idx;
      logic [1:0]       br_type;
      logic             pred;
      logic [PC_W-1:0]  target;
      logic [PC_W-1:0]  pc_plus1;
   } entry_t;

   entry_t           q [Q_DEPTH];
   logic [PTR_W-1:0] head_ptr;
   logic [PTR_W-1:0] tail_ptr;
   logic [OCC_W-1:0] occ;

   entry_t           head_entry;
   entry_t           new_entry;
   logic [1:0]       rd_cnt;
   logic             q_empty;
   logic             resolve_fire;
   logic             mispred_fire;
   logic             pop;
   logic             push;

   bp_counter_table #(
      .IDX_W    (IDX_W),
      .CNT_INIT (CNT_INIT)
   ) u_counter_table (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_idx    (issue_pc[IDX_W-1:0]),
      .rd_cnt    (rd_cnt),
      .upd_en    (resolve_fire),
      .upd_idx   (head_entry.idx),
      .upd_taken (resolve_taken)
   );

   assign q_empty      = (occ == '0);
   assign head_entry   = q[head_ptr];
   assign resolve_fire = resolve_valid & ~q_empty;
   assign mispred_fire = resolve_fire & resolve_mispred;
   assign pop          = resolve_fire & ~resolve_mispred;

   // A correct resolve frees the head slot in the same cycle, so a full queue can still accept.
   assign issue_ready  = (occ < OCC_W'(Q_DEPTH)) | pop;
   assign push         = issue_valid & issue_ready & (issue_type != BR_NONE) & ~mispred_fire;

   assign pred_taken   = rd_cnt[1];

   always_comb begin
      new_entry          = '0;
      new_entry.idx      = issue_pc[IDX_W-1:0];
      new_entry.br_type  = issue_type;
      new_entry.pred     = rd_cnt[1];
      new_entry.target   = issue_target;
      new_entry.pc_plus1 = issue_pc + PC_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_ptr    <= '0;
         tail_ptr    <= '0;
         occ         <= '0;
         redirect    <= 1'b0;
         redirect_pc <= '0;
         for (int i = 0; i < Q_DEPTH; i++) q[i] <= '0;
      end else begin
         redirect <= mispred_fire;
         if (mispred_fire) begin
            // Everything behind the head was fetched down the wrong path.
            redirect_pc <= resolve_taken ? head_entry.target : head_entry.pc_plus1;
            head_ptr    <= '0;
            tail_ptr    <= '0;
            occ         <= '0;
         end else begin
            if (push) begin
               q[tail_ptr] <= new_entry;
               tail_ptr    <= tail_ptr + PTR_W'(1);
            end
            if (pop) head_ptr <= head_ptr + PTR_W'(1);
            case ({push, pop})
               2'b10:   occ <= occ + OCC_W'(1);
               2'b01:   occ <= occ - OCC_W'(1);
               default: occ <= occ;
            endcase
         end
      end
   end

   assign last_pred = q_empty ? 1'b0  : head_entry.pred;
   assign pred_type = q_empty ? 2'b00 : head_entry.br_type;
   assign occupancy = occ;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: a behavioural model predicts each
// cycle's outputs, pushes them to a scoreboard, and they are compared after the edge.
module tb_branch_predictor;
   import ev20_pkg::*;

   localparam int PC_W    = 11;
   localparam int IDX_W   = 6;
   localparam int Q_DEPTH = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            issue_valid = 1'b0;
   logic [1:0]      issue_type = 2'b00;
   logic [PC_W-1:0] issue_pc = '0;
   logic [PC_W-1:0] issue_target = '0;
   logic            issue_ready;
   logic            pred_taken;
   logic            last_pred;
   logic [1:0]      pred_type;
   logic            resolve_valid = 1'b0;
   logic            resolve_taken = 1'b0;
   logic            resolve_mispred = 1'b0;
   logic            redirect;
   logic [PC_W-1:0] redirect_pc;
   logic [2:0]      occupancy;

   always #5 clk = ~clk;

   branch_predictor #(
      .PC_W     (PC_W),
      .IDX_W    (IDX_W),
      .Q_DEPTH  (Q_DEPTH),
      .CNT_INIT (2'b01)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .issue_valid     (issue_valid),
      .issue_type      (issue_type),
      .issue_pc        (issue_pc),
      .issue_target    (issue_target),
      .issue_ready     (issue_ready),
      .pred_taken      (pred_taken),
      .last_pred       (last_pred),
      .pred_type       (pred_type),
      .resolve_valid   (resolve_valid),
      .resolve_taken   (resolve_taken),
      .resolve_mispred (resolve_mispred),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .occupancy       (occupancy)
   );

   typedef struct {
      logic [5:0]  idx;
      logic [1:0]  typ;
      logic        pred;
      logic [10:0] target;
      logic [10:0] pcp1;
   } m_entry_t;

   typedef struct {
      logic [2:0]  occ;
      logic        last_pred;
      logic [1:0]  ptype;
      logic        redirect;
      logic [10:0] rpc;
   } exp_t;

   m_entry_t    m_q[$];
   exp_t        sb[$];
   logic [1:0]  m_cnt [64];
   logic        m_redir;
   logic [10:0] m_rpc;
   logic        p_seen;
   logic        r_seen;
   int          vectors = 0;
   int          miscompares = 0;

   task automatic m_reset();
      m_q.delete();
      sb.delete();
      for (int i = 0; i < 64; i++) m_cnt[i] = 2'b01;
      m_redir = 1'b0;
      m_rpc   = '0;
   endtask

   // Drive one cycle, predict its effect, and check comb then registered outputs.
   task automatic run_cycle(input logic iv, input logic [1:0] it, input logic [10:0] ipc,
                            input logic [10:0] itgt, input logic rv, input logic rt,
                            input logic rm, output logic p_out, output logic r_out);
      logic     exp_pred, exp_ready, fire, mis, push, nonempty;
      m_entry_t h, n;
      exp_t     e;
      issue_valid = iv; issue_type = it; issue_pc = ipc; issue_target = itgt;
      resolve_valid = rv; resolve_taken = rt; resolve_mispred = rm;
      #1;
      nonempty  = (m_q.size() != 0);
      exp_pred  = m_cnt[ipc[5:0]][1];
      exp_ready = (m_q.size() < Q_DEPTH) || (rv && !rm && nonempty);
      p_out = pred_taken;
      r_out = issue_ready;
      if (iv) begin
         vectors++;
         if (pred_taken !== exp_pred) begin
            miscompares++;
            $display("FAIL pred_taken pc=%03h: got %b expected %b", ipc, pred_taken, exp_pred);
         end
      end
      vectors++;
      if (issue_ready !== exp_ready) begin
         miscompares++;
         $display("FAIL issue_ready: got %b expected %b", issue_ready, exp_ready);
      end
      fire = rv && nonempty;
      mis  = fire && rm;
      push = iv && exp_ready && (it != 2'b00) && !mis;
      m_redir = 1'b0;
      if (fire) begin
         h = m_q[0];
         if (rt) m_cnt[h.idx] = (m_cnt[h.idx] == 2'b11) ? 2'b11 : m_cnt[h.idx] + 2'd1;
         else    m_cnt[h.idx] = (m_cnt[h.idx] == 2'b00) ? 2'b00 : m_cnt[h.idx] - 2'd1;
         if (mis) begin
            m_redir = 1'b1;
            m_rpc   = rt ? h.target : h.pcp1;
            m_q.delete();
         end else begin
            void'(m_q.pop_front());
         end
      end
      if (push) begin
         n.idx = ipc[5:0]; n.typ = it; n.pred = exp_pred; n.target = itgt; n.pcp1 = ipc + 11'd1;
         m_q.push_back(n);
      end
      e.occ = 3'(m_q.size());
      e.last_pred = 1'b0;
      e.ptype = 2'b00;
      if (m_q.size() != 0) begin
         e.last_pred = m_q[0].pred;
         e.ptype     = m_q[0].typ;
      end
      e.redirect = m_redir;
      e.rpc      = m_rpc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      vectors++;
      if (occupancy !== e.occ) begin
         miscompares++;
         $display("FAIL occupancy: got %0d expected %0d", occupancy, e.occ);
      end
      vectors++;
      if (last_pred !== e.last_pred) begin
         miscompares++;
         $display("FAIL last_pred: got %b expected %b", last_pred, e.last_pred);
      end
      vectors++;
      if (pred_type !== e.ptype) begin
         miscompares++;
         $display("FAIL pred_type: got %b expected %b", pred_type, e.ptype);
      end
      vectors++;
      if (redirect !== e.redirect) begin
         miscompares++;
         $display("FAIL redirect: got %b expected %b", redirect, e.redirect);
      end
      vectors++;
      if (redirect_pc !== e.rpc) begin
         miscompares++;
         $display("FAIL redirect_pc: got %03h expected %03h", redirect_pc, e.rpc);
      end
   endtask

   task automatic drain();
      for (int g = 0; g < 16 && m_q.size() != 0; g++)
         run_cycle(1'b0, 2'b00, 11'h0, 11'h0, 1'b1, m_q[0].pred, 1'b0, p_seen, r_seen);
   endtask

   task automatic test_reset();
      m_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (occupancy !== 3'd0 || redirect !== 1'b0 || redirect_pc !== 11'h000 ||
          last_pred !== 1'b0 || pred_type !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_state: got occ=%0d redir=%b rpc=%03h lp=%b pt=%b expected all zero",
                  occupancy, redirect, redirect_pc, last_pred, pred_type);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      vectors++;
      if (issue_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_ready: got %b expected 1", issue_ready);
      end
   endtask

   task automatic test_predict();
      run_cycle(1'b1, BR_JZE, 11'h040, 11'h200, 1'b0, 1'b0, 1'b0, p_seen, r_seen);
      vectors++;
      if (p_seen !== 1'b0 || last_pred !== 1'b0 || pred_type !== 2'b01 || occupancy !== 3'd1) begin
         miscompares++;
         $display("FAIL first_issue: got pred=%b lp=%b pt=%b occ=%0d expected 0 0 01 1",
                  p_seen, last_pred, pred_type, occupancy);
      end
   endtask

   task automatic test_saturate();
      run_cycle(1'b0, 2'b00, 11'h0, 11'h0, 1'b1, 1'b1, 1'b1, p_seen, r_seen);
      run_cycle(1'b1, BR_JNE, 11'h040, 11'h200, 1'b0, 1'b0, 1'b0, p_seen, r_seen);
      vectors++;
      if (p_seen !== 1'b1) begin
         miscompares++;
         $display("FAIL train_to_10: got %b expected 1", p_seen);
      end
      run_cycle(1'b0, 2'b00, 11'h0, 11'h0, 1'b1, 1'b1, 1'b0, p_seen, r_seen);
      run_cycle(1'b1, BR_JCY, 11'h040, 11'h200, 1'b0, 1'b0, 1'b0, p_seen, r_seen);
      run_cycle(1'b0, 2'b00, 11'h0, 11'h0, 1'b1, 1'b1, 1'b0, p_seen, r_seen);
      run_cycle(1'b1, BR_JZE, 11'h040, 11'h200, 1'b0, 1'b0, 1'b0, p_seen, r_seen);
      // Counter is saturated at 11; one not-taken must leave it predicting taken.
      run_cycle(1'b0, 2'b00, 11'h0, 11'h0, 1'b1, 1'b0, 1'b1, p_seen, r_seen);
      run_cycle(1'b1, BR_JZE, 11'h040, 11'h200, 1'b0, 1'b0, 1'b0, p_seen, r_seen);
      vectors++;
      if (p_seen !== 1'b1) begin
         miscompares++;
         $display("FAIL saturate_11: got %b expected 1", p_seen);
      end
   endtask

   task automatic test_full();
      for (int i = 0; i < 4; i++)
         run_cycle(1'b1, BR_JNE, 11'h100 + 11'(i), 11'h180, 1'b0, 1'b0, 1'b0, p_seen, r_seen);
      run_cycle(1'b1, BR_JCY, 11'h104, 11'h180, 1'b0, 1'b0, 1'b0, p_seen, r_seen);
      vectors++;
      if (r_seen !== 1'b0 || occupancy !== 3'd4) begin
         miscompares++;
         $display("FAIL full_block: got ready=%b occ=%0d expected 0 4", r_seen, occupancy);
      end
      run_cycle(1'b1, BR_JCY, 11'h104, 11'h180, 1'b1, m_q[0].pred, 1'b0, p_seen, r_seen);
      vectors++;
      if (r_seen !== 1'b1 || occupancy !== 3'd4) begin
         miscompares++;
         $display("FAIL full_push_pop: got ready=%b occ=%0d expected 1 4", r_seen, occupancy);
      end
      drain();
      run_cycle(1'b1, 2'b00, 11'h105, 11'h180, 1'b0, 1'b0, 1'b0, p_seen, r_seen);
      vectors++;
      if (occupancy !== 3'd0) begin
         miscompares++;
         $display("FAIL illegal_type: got occ=%0d expected 0", occupancy);
      end
   endtask

   task automatic test_mispredict_flush();
      run_cycle(1'b1, BR_JZE, 11'h0A0, 11'h123, 1'b0, 1'b0, 1'b0, p_seen, r_seen);
      run_cycle(1'b1, BR_JNE, 11'h0A1, 11'h124, 1'b0, 1'b0, 1'b0, p_seen, r_seen);
      run_cycle(1'b1, BR_JCY, 11'h0A2, 11'h125, 1'b0, 1'b0, 1'b0, p_seen, r_seen);
      run_cycle(1'b1, BR_JZE, 11'h0A3, 11'h126, 1'b1, 1'b1, 1'b1, p_seen, r_seen);
      vectors++;
      if (redirect !== 1'b1 || redirect_pc !== 11'h123 || occupancy !== 3'd0) begin
         miscompares++;
         $display("FAIL mispred_flush: got redir=%b rpc=%03h occ=%0d expected 1 123 0",
                  redirect, redirect_pc, occupancy);
      end
      run_cycle(1'b0, 2'b00, 11'h0, 11'h0, 1'b0, 1'b0, 1'b0, p_seen, r_seen);
      vectors++;
      if (redirect !== 1'b0) begin
         miscompares++;
         $display("FAIL redirect_pulse: got %b expected 0", redirect);
      end
   endtask

   task automatic test_wrap();
      run_cycle(1'b1, BR_JNE, 11'h7FF, 11'h010, 1'b0, 1'b0, 1'b0, p_seen, r_seen);
      run_cycle(1'b0, 2'b00, 11'h0, 11'h0, 1'b1, 1'b0, 1'b1, p_seen, r_seen);
      vectors++;
      if (redirect !== 1'b1 || redirect_pc !== 11'h000) begin
         miscompares++;
         $display("FAIL pc_wrap: got redir=%b rpc=%03h expected 1 000", redirect, redirect_pc);
      end
      run_cycle(1'b0, 2'b00, 11'h0, 11'h0, 1'b1, 1'b1, 1'b1, p_seen, r_seen);
   endtask

   task automatic test_back_to_back();
      logic        iv, rv, rt, rm;
      logic [1:0]  it;
      logic [10:0] pc, tg;
      for (int k = 0; k < 60; k++) begin
         iv = 1'($urandom_range(0, 3) != 0);
         it = 2'($urandom_range(0, 3));
         pc = 11'($urandom_range(0, 2047));
         tg = 11'($urandom_range(0, 2047));
         rv = 1'($urandom_range(0, 1));
         rt = 1'($urandom_range(0, 1));
         if (m_q.size() != 0) rm = (rt != m_q[0].pred) && ($urandom_range(0, 2) == 0);
         else                 rm = 1'($urandom_range(0, 1));
         if (m_q.size() != 0 && !rm) rt = m_q[0].pred;
         run_cycle(iv, it, pc, tg, rv, rt, rm, p_seen, r_seen);
      end
   endtask

   task automatic test_reset_mid();
      run_cycle(1'b1, BR_JZE, 11'h300, 11'h050, 1'b0, 1'b0, 1'b0, p_seen, r_seen);
      run_cycle(1'b1, BR_JNE, 11'h301, 11'h051, 1'b0, 1'b0, 1'b0, p_seen, r_seen);
      issue_valid = 1'b0;
      resolve_valid = 1'b1; resolve_taken = 1'b1; resolve_mispred = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (occupancy !== 3'd0 || last_pred !== 1'b0 || pred_type !== 2'b00 ||
          redirect !== 1'b0 || redirect_pc !== 11'h000) begin
         miscompares++;
         $display("FAIL reset_mid: got occ=%0d lp=%b pt=%b redir=%b rpc=%03h expected all zero",
                  occupancy, last_pred, pred_type, redirect, redirect_pc);
      end
      resolve_valid = 1'b0; resolve_taken = 1'b0; resolve_mispred = 1'b0;
      m_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run_cycle(1'b0, 2'b00, 11'h0, 11'h0, 1'b0, 1'b0, 1'b0, p_seen, r_seen);
      run_cycle(1'b1, BR_JZE, 11'h040, 11'h200, 1'b0, 1'b0, 1'b0, p_seen, r_seen);
      vectors++;
      if (p_seen !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_counters: got %b expected 0", p_seen);
      end
   endtask

   initial begin
      test_reset();
      test_predict();
      test_saturate();
      drain();
      test_full();
      drain();
      test_mispredict_flush();
      test_wrap();
      drain();
      test_back_to_back();
      drain();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
